// File: rtl/phase_delay_gen.sv
// phase_delay_gen: delay engine of the phase delay board.
// Synchronises the asynchronous reference input, detects its rising edge,
// waits delaySet clk cycles and then emits a PULSE_LEN-cycle pulse on sigOut.
// Edges arriving while a delay or pulse is in flight are ignored.
// Optional feature: define PHASE_MISS_CNT_EN to count those ignored edges
// on missCnt (saturating at 255); otherwise missCnt is tied to zero.

module phase_delay_gen #(
    parameter int SIZE      = 10,
    parameter int PULSE_LEN = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sigIn,
    input  logic [SIZE-1:0] delaySet,
    output logic            sigOut,
    output logic            busy,
    output logic [7:0]      missCnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        PULSE = 2'd2
    } stateT;

    // Terminal value of the 8-bit pulse counter
    localparam logic [7:0] PULSE_LAST = 8'(PULSE_LEN - 1);

    stateT           state;
    stateT           nextState;
    logic            s1;
    logic            s2;
    logic            s3;
    logic            edgeDet;
    logic [SIZE-1:0] delayLat;
    logic [SIZE-1:0] dCnt;
    logic [7:0]      pCnt;
    logic            delayDone;
    logic            pulseDone;

    // Two-flop synchroniser for sigIn plus a history flop for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sigIn;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edgeDet   = s2 & ~s3;
    // Compare happens before increment, so dCnt never needs to pass 2^SIZE-1
    assign delayDone = (dCnt == delayLat);
    assign pulseDone = (pCnt == PULSE_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: edges are only accepted from IDLE
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (edgeDet) begin
                    nextState = DELAY;
                end
            end
            DELAY: begin
                if (delayDone) begin
                    nextState = PULSE;
                end
            end
            PULSE: begin
                if (pulseDone) begin
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Counters, latched delay and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            delayLat <= '0;
            dCnt     <= '0;
            pCnt     <= '0;
            sigOut   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (edgeDet) begin
                        delayLat <= delaySet;
                        dCnt     <= '0;
                        busy     <= 1'b1;
                    end
                end
                DELAY: begin
                    if (delayDone) begin
                        sigOut <= 1'b1;
                        pCnt   <= '0;
                    end else begin
                        dCnt <= dCnt + 1'b1;
                    end
                end
                PULSE: begin
                    if (pulseDone) begin
                        sigOut <= 1'b0;
                        busy   <= 1'b0;
                    end else begin
                        pCnt <= pCnt + 1'b1;
                    end
                end
                default: begin
                    sigOut <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

`ifdef PHASE_MISS_CNT_EN
    // Saturating count of edges that arrived while a delay or pulse was running
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            missCnt <= 8'd0;
        end else if (edgeDet && (state != IDLE) && (missCnt != 8'd255)) begin
            missCnt <= missCnt + 8'd1;
        end
    end
`else
    assign missCnt = 8'd0;
`endif

endmodule

// File: tb/tb_phase_delay_gen.sv
// tb_phase_delay_gen: randomized and directed bench for phase_delay_gen.
// A timeline model predicts busy/sigOut/missCnt for every cycle; directed
// pulse measurements pin the model with hand-computed latencies and widths.
// Compile with PHASE_MISS_CNT_EN defined to exercise the missed-edge counter.

module tb_phase_delay_gen;

    localparam int SIZE = 10;
    localparam int PL   = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            sigIn = 1'b0;
    logic [SIZE-1:0] delaySet = '0;
    logic            sigOut;
    logic            busy;
    logic [7:0]      missCnt;

    phase_delay_gen #(
        .SIZE      (SIZE),
        .PULSE_LEN (PL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sigIn    (sigIn),
        .delaySet (delaySet),
        .sigOut   (sigOut),
        .busy     (busy),
        .missCnt  (missCnt)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Expected missCnt saturation value for this build
`ifdef PHASE_MISS_CNT_EN
    localparam int MISS_ON = 1;
`else
    localparam int MISS_ON = 0;
`endif

    // Model state: a timeline of the accepted trigger, in clk-edge indices
    int   cyc      = 0;
    logic hist [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    int   startT   = -100000;
    int   busyEnd  = -100000;
    int   sigStart = -100000;
    int   missM    = 0;

    // Scoreboard counters and directed-check handshake
    int    nChecks = 0;
    int    nFails  = 0;
    int    pinSeq  = 0;
    int    pinDone = 0;
    string pinName = "";
    int    pinGot  = 0;
    int    pinWant = 0;

    // Reference model: a rise first sampled at edge j makes cycle j+1 the
    // trigger cycle T; delaySet during T fixes the timeline if idle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) hist[i] = 1'b0;
            startT   = -100000;
            busyEnd  = -100000;
            sigStart = -100000;
            missM    = 0;
        end else begin
            int t;
            cyc = cyc + 1;
            hist[3] = hist[2];
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = sigIn;
            if (hist[2] && !hist[3]) begin
                t = cyc - 1;
                if (t > busyEnd) begin
                    startT   = t;
                    busyEnd  = t + int'(delaySet) + 1 + PL;
                    sigStart = t + int'(delaySet) + 2;
                end else if (missM < 255) begin
                    missM = missM + 1;
                end
            end
        end
    end

    // Single compare process: per-cycle model checks plus directed pins
    always @(negedge clk) begin
        int expSig;
        int expBusy;
        int expMiss;
        if (rst) begin
            expSig  = 0;
            expBusy = 0;
            expMiss = 0;
        end else begin
            expSig  = (cyc >= sigStart && cyc <= busyEnd) ? 1 : 0;
            expBusy = (cyc >= startT + 1 && cyc <= busyEnd) ? 1 : 0;
            expMiss = MISS_ON ? missM : 0;
        end
        nChecks = nChecks + 1;
        if (int'(sigOut) != expSig) begin
            nFails = nFails + 1;
            $display("[TB] FAIL sigOut @%0t: got %0d, want %0d", $time, sigOut, expSig);
        end
        nChecks = nChecks + 1;
        if (int'(busy) != expBusy) begin
            nFails = nFails + 1;
            $display("[TB] FAIL busy @%0t: got %0d, want %0d", $time, busy, expBusy);
        end
        nChecks = nChecks + 1;
        if (int'(missCnt) != expMiss) begin
            nFails = nFails + 1;
            $display("[TB] FAIL missCnt @%0t: got %0d, want %0d", $time, missCnt, expMiss);
        end
        if (pinSeq != pinDone) begin
            pinDone = pinSeq;
            nChecks = nChecks + 1;
            if (pinGot != pinWant) begin
                nFails = nFails + 1;
                $display("[TB] FAIL %s: got %0d, want %0d", pinName, pinGot, pinWant);
            end
        end
    end

    // Hand a directed comparison to the compare process
    task automatic checkOutput(input string name, input int got, input int want);
        pinName = name;
        pinGot  = got;
        pinWant = want;
        pinSeq  = pinSeq + 1;
        @(negedge clk);
        #1;
    endtask

    // Drive inputs for one cycle, away from the active edge
    task automatic applyStimulus(input logic s, input logic [SIZE-1:0] d);
        @(posedge clk);
        #2;
        sigIn    = s;
        delaySet = d;
    endtask

    // Asynchronous reset pulse, asserted and released between edges
    task automatic doReset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #4;
        rst = 1'b0;
    endtask

    // Wait (bounded) for the DUT to go idle
    task automatic waitIdle(input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) checkOutput("idleTimeout", 1, 0);
    endtask

    // One trigger with delay d; edges counted from the first sampling edge E0
    task automatic measurePulse(input int d, output int riseEdge,
                                output int hiCnt, output int busyCnt);
        int limit;
        riseEdge = -1;
        hiCnt    = 0;
        busyCnt  = 0;
        limit    = d + PL + 20;
        waitIdle(2000);
        repeat (4) applyStimulus(1'b0, SIZE'(d));
        applyStimulus(1'b1, SIZE'(d));
        @(posedge clk);
        for (int k = 1; k <= limit; k++) begin
            @(posedge clk);
            #1;
            if (busy) busyCnt++;
            if (sigOut) begin
                if (riseEdge < 0) riseEdge = k;
                hiCnt++;
            end
            if (riseEdge >= 0 && !busy) break;
        end
        sigIn = 1'b0;
    endtask

    // Main stimulus sequence
    initial begin
        int rise;
        int hi;
        int bz;
        int pulses;
        int prevSig;
        int sBefore;
        int sAfter;
        int bAfter;

        // Reset held with sigIn toggling, then quiet release
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #2;
            sigIn = ~sigIn;
        end
        sigIn = 1'b0;
        #3;
        rst = 1'b0;
        hi = 0;
        bz = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (sigOut) hi++;
            if (busy) bz++;
        end
        checkOutput("noSpuriousSig", hi, 0);
        checkOutput("noSpuriousBusy", bz, 0);

        // D=5: rise D+3 edges after E0, PL high cycles, busy T+1..T+D+1+PL
        measurePulse(5, rise, hi, bz);
        checkOutput("d5Rise", rise, 8);
        checkOutput("d5High", hi, 8);
        checkOutput("d5Busy", bz, 14);

        // Minimum and maximum delay
        measurePulse(0, rise, hi, bz);
        checkOutput("d0Rise", rise, 3);
        checkOutput("d0High", hi, 8);
        measurePulse(1023, rise, hi, bz);
        checkOutput("d1023Rise", rise, 1026);
        checkOutput("d1023High", hi, 8);

        // Second edge during the delay and a late delaySet change are ignored
        doReset();
        repeat (4) applyStimulus(1'b0, SIZE'(20));
        applyStimulus(1'b1, SIZE'(20));
        @(posedge clk);
        rise    = -1;
        pulses  = 0;
        prevSig = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (sigOut && prevSig == 0) begin
                pulses++;
                if (rise < 0) rise = k;
            end
            prevSig = int'(sigOut);
            if (k == 5) begin
                delaySet = SIZE'(3);
                sigIn    = 1'b0;
            end
            if (k == 9) sigIn = 1'b1;
        end
        sigIn = 1'b0;
        checkOutput("ignoreRise", rise, 23);
        checkOutput("ignorePulses", pulses, 1);
        checkOutput("ignoreMiss", int'(missCnt), MISS_ON);

        // Reset mid-pulse drops outputs immediately
        measurePulse(5, rise, hi, bz);
        waitIdle(100);
        repeat (4) applyStimulus(1'b0, SIZE'(5));
        applyStimulus(1'b1, SIZE'(5));
        @(posedge clk);
        repeat (10) @(posedge clk);
        #3;
        sBefore = int'(sigOut);
        rst = 1'b1;
        #1;
        sAfter = int'(sigOut);
        bAfter = int'(busy);
        sigIn  = 1'b0;
        repeat (2) @(posedge clk);
        #4;
        rst = 1'b0;
        checkOutput("midPulseBefore", sBefore, 1);
        checkOutput("rstSigOut", sAfter, 0);
        checkOutput("rstBusy", bAfter, 0);
        measurePulse(5, rise, hi, bz);
        checkOutput("afterRstRise", rise, 8);

        // Randomized triggers, delays and occasional resets
        for (int i = 0; i < 300; i++) begin
            int hold;
            logic s;
            logic [SIZE-1:0] d;
            s    = 1'($urandom_range(0, 1));
            d    = (i % 5 == 0) ? SIZE'($urandom_range(0, 40)) : delaySet;
            hold = $urandom_range(1, 8);
            applyStimulus(s, d);
            repeat (hold - 1) @(posedge clk);
            if ($urandom_range(0, 60) == 0) doReset();
        end
        sigIn = 1'b0;

        // Many edges during one long delay saturate the miss counter
        doReset();
        waitIdle(100);
        repeat (4) applyStimulus(1'b0, SIZE'(1023));
        applyStimulus(1'b1, SIZE'(1023));
        for (int i = 0; i < 640; i++) begin
            @(posedge clk);
            #2;
            sigIn = ~sigIn;
        end
        sigIn = 1'b0;
        checkOutput("missSat", int'(missCnt), 255 * MISS_ON);
        waitIdle(1200);
        repeat (4) applyStimulus(1'b0, SIZE'(2));
        checkOutput("missHeld", int'(missCnt), 255 * MISS_ON);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #3ms;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
